rr_arbiter_8: RTL and testbench



---
 rtl/arb_pkg.sv | 34 +++
 rtl/rr_arbiter_8_if.sv | 26 ++
 rtl/gnt_decoder.sv | 15 +
 rtl/rr_arbiter_8.sv | 114 +++++++++++
 tb/tb_rr_arbiter_8.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types, sizes and the rotating-priority search for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Search starts one past last_idx and wraps, so last_idx itself is considered last.
    function automatic rr_pick_t next_rr(input logic [N_REQ-1:0] req,
                                         input logic [IDX_W-1:0] last_idx);
        rr_pick_t         pick;
        logic [IDX_W-1:0] cand;
        pick.found = 1'b0;
        pick.idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_idx + IDX_W'(i);
            if (!pick.found && req[cand]) begin
                pick.found = 1'b1;
                pick.idx   = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if import arb_pkg::*; ;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic [IDX_W-1:0] gnt_idx;
    logic             timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx,
        output timeout
    );

endinterface

// File: rtl/gnt_decoder.sv
// Enable-gated 3-to-8 one-hot decode; output is all-zero while en_i is low.
module gnt_decoder import arb_pkg::*; (
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_REQ-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters; each grant is held until its owner drops req.
// Define ARB_TIMEOUT_EN to revoke any grant held for MAX_HOLD cycles and pulse timeout.
module rr_arbiter_8 import arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 16
)
`endif
(
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  bus
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0] last_idx_q, last_idx_d;
    logic             gnt_valid;
    logic             expired;
    logic [N_REQ-1:0] gnt_w;
    rr_pick_t         pick;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign gnt_valid = (state_q == GRANT);

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        pick       = '0;
        expired    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                pick = next_rr(bus.req, last_idx_q);
                if (pick.found) begin
                    state_d   = GRANT;
                    gnt_idx_d = pick.idx;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d = '0;
`endif
                end
            end
            GRANT: begin
`ifdef ARB_TIMEOUT_EN
                expired    = (hold_cnt_q == HOLD_LAST) && bus.req[gnt_idx_q];
                hold_cnt_d = hold_cnt_q + 8'd1;
`endif
                // A revoked owner still requests but is searched last, like a fresh request.
                if (!bus.req[gnt_idx_q] || expired) begin
                    last_idx_d = gnt_idx_q;
                    pick       = next_rr(bus.req, gnt_idx_q);
`ifdef ARB_TIMEOUT_EN
                    timeout_d  = expired;
                    hold_cnt_d = '0;
`endif
                    if (pick.found) begin
                        gnt_idx_d = pick.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= '0;
            last_idx_q <= IDX_W'(N_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    gnt_decoder u_gnt_decoder (
        .en_i     (gnt_valid),
        .idx_i    (gnt_idx_q),
        .onehot_o (gnt_w)
    );

    assign bus.gnt       = gnt_w;
    assign bus.gnt_valid = gnt_valid;
    assign bus.gnt_idx   = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout   = timeout_q;
`else
    assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: reset, rotation, wrap, re-request, no preemption, hold/timeout.
module tb_rr_arbiter_8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    rr_arbiter_8_if bus();

`ifdef ARB_TIMEOUT_EN
    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
`else
    rr_arbiter_8 dut (
`endif
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_gnt(input string tag, input logic [7:0] exp);
        check(tag, bus.gnt, exp);
        check({tag, "_vld"}, bus.gnt_valid, exp != 8'h00);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        bus.req  = 8'h00;
        tick();
        tick();
        check("rst_gnt", bus.gnt, 8'h00);
        check("rst_vld", bus.gnt_valid, 1'b0);
        check("rst_idx", bus.gnt_idx, 3'd0);
        check("rst_tmo", bus.timeout, 1'b0);
        rst = 1'b0;

        // Grant 0, then reset mid-grant must clear outputs without a clock edge.
        bus.req = 8'h01;
        tick();
        check_gnt("pre_rst", 8'h01);
        #2 rst = 1'b1;
        #1;
        check_gnt("async_rst", 8'h00);
        #1 rst = 1'b0;
        bus.req = 8'hFF;
        tick();
        check_gnt("post_rst", 8'h01);

        // Rotation over all 8 with one-cycle drops and no idle gap.
        for (int k = 0; k < 8; k++) begin
            check_gnt("rot_first", 8'(1 << k));
            tick();
            check_gnt("rot_hold", 8'(1 << k));
            bus.req = 8'hFF ^ 8'(1 << k);
            tick();
            bus.req = 8'hFF;
        end
        check_gnt("rot_wrap", 8'h01);

        // Wrap: last owner 6, search order 7,0 picks 0 before 6.
        bus.req = 8'h00;
        tick();
        check_gnt("idle0", 8'h00);
        bus.req = 8'h40;
        tick();
        check_gnt("own6", 8'h40);
        bus.req = 8'h00;
        tick();
        check_gnt("idle6", 8'h00);
        bus.req = 8'h41;
        tick();
        check_gnt("wrap0", 8'h01);
        check("wrap0_idx", bus.gnt_idx, 3'd0);
        bus.req = 8'h40;
        tick();
        check_gnt("wrap6", 8'h40);
        check("wrap6_idx", bus.gnt_idx, 3'd6);

        // Sole requester drops for one cycle and is regranted.
        bus.req = 8'h00;
        tick();
        bus.req = 8'h10;
        tick();
        check_gnt("sole_gnt", 8'h10);
        bus.req = 8'h00;
        tick();
        check_gnt("sole_gap", 8'h00);
        bus.req = 8'h10;
        tick();
        check_gnt("sole_regnt", 8'h10);

        // No preemption while owner 3 holds its request.
        bus.req = 8'h00;
        tick();
        bus.req = 8'h08;
        tick();
        check_gnt("np_own3", 8'h08);
        bus.req = 8'hFF;
        tick();
        check_gnt("np_hold1", 8'h08);
        tick();
        check_gnt("np_hold2", 8'h08);
        bus.req = 8'hF7;
        tick();
        check_gnt("np_next", 8'h10);
        check("np_next_idx", bus.gnt_idx, 3'd4);

        // Permanent req=05 from idle with last owner 4: grant 0 first.
        bus.req = 8'h00;
        tick();
        bus.req = 8'h05;
        tick();
        check_gnt("hold_start", 8'h01);
        check("hold_start_tmo", bus.timeout, 1'b0);
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c < 4; c++) begin
            tick();
            check_gnt("to_hold0", 8'h01);
            check("to_hold0_tmo", bus.timeout, 1'b0);
        end
        tick();
        check_gnt("to_gnt2", 8'h04);
        check("to_pulse1", bus.timeout, 1'b1);
        for (int c = 1; c < 4; c++) begin
            tick();
            check_gnt("to_hold2", 8'h04);
            check("to_hold2_tmo", bus.timeout, 1'b0);
        end
        tick();
        check_gnt("to_gnt0", 8'h01);
        check("to_pulse2", bus.timeout, 1'b1);
        tick();
        check("to_pulse_end", bus.timeout, 1'b0);
`else
        for (int c = 0; c < 12; c++) begin
            tick();
            check_gnt("nohold", 8'h01);
            check("nohold_tmo", bus.timeout, 1'b0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
